// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Frame states, prefix bytes and the list of non-key bytes to drop.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR_LO = 8'h00;
    localparam logic [7:0] PS2_ERR_HI = 8'hFF;

    localparam logic [7:0] PS2_FAKE_LSH = 8'h12;
    localparam logic [7:0] PS2_FAKE_RSH = 8'h59;

    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // Keyboard housekeeping bytes that never describe a key.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == PS2_ACK)    || (b == PS2_BAT_OK) ||
               (b == PS2_ECHO)   || (b == PS2_RESEND) ||
               (b == PS2_ERR_LO) || (b == PS2_ERR_HI);
    endfunction

    // Shift codes the keyboard wraps around extended keys.
    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == PS2_FAKE_LSH) || (b == PS2_FAKE_RSH);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser plus saturating glitch filter for one raw PS/2 line.
// Output only follows the input after FILTER_LEN agreeing samples.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic CLK12,
    input  logic RESET,
    input  logic raw,
    output logic filt
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser for the asynchronous line, idle-high reset.
    always_ff @(posedge CLK12) begin
        if (RESET) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreeing samples; flip on the last one.
    always_ff @(posedge CLK12) begin
        if (RESET) begin
            filt <= 1'b1;
            cnt  <= '0;
        end else if (sync2 == filt) begin
            cnt  <= '0;
        end else if (cnt == CW'(FILTER_LEN - 1)) begin
            filt <= sync2;
            cnt  <= '0;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frames bytes and turns them into key events.
// Strips E0/F0/E1 prefixes and drops housekeeping bytes.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int BIT_TIMEOUT = 1200
) (
    input  logic       CLK12,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       KEY_STROBE,
    output logic       KEY_PRESSED,
    output logic [7:0] KEY_CODE,
    output logic       KEY_EXTENDED,
    output logic       FRAME_ERR
);

    localparam int WDW = $clog2(BIT_TIMEOUT);
    // Error lands BIT_TIMEOUT cycles after the edge cycle.
    localparam logic [WDW-1:0] WD_LAST = WDW'(BIT_TIMEOUT - 2);

    logic           clk_f;
    logic           data_f;
    logic           clk_q;
    logic           fall;
    ps2_state_t     state;
    logic [2:0]     bitn;
    logic [7:0]     shreg;
    logic           par;
    logic [WDW-1:0] wd;
    logic           ext;
    logic           brk;
    logic [2:0]     skip;
    logic           timeout;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .CLK12 (CLK12),
        .RESET (RESET),
        .raw   (PS2_CLK),
        .filt  (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .CLK12 (CLK12),
        .RESET (RESET),
        .raw   (PS2_DATA),
        .filt  (data_f)
    );

    assign fall    = clk_q & ~clk_f;
    assign timeout = (state != IDLE) && !fall && (wd == WD_LAST);

    // Frame FSM, watchdog and byte decoder with registered outputs.
    always_ff @(posedge CLK12) begin
        if (RESET) begin
            clk_q        <= 1'b1;
            state        <= IDLE;
            bitn         <= '0;
            shreg        <= '0;
            par          <= 1'b0;
            wd           <= '0;
            ext          <= 1'b0;
            brk          <= 1'b0;
            skip         <= '0;
            KEY_STROBE   <= 1'b0;
            KEY_PRESSED  <= 1'b0;
            KEY_CODE     <= 8'h00;
            KEY_EXTENDED <= 1'b0;
            FRAME_ERR    <= 1'b0;
        end else begin
            clk_q      <= clk_f;
            KEY_STROBE <= 1'b0;
            FRAME_ERR  <= 1'b0;

            if (fall) begin
                wd <= '0;
            end else if (state != IDLE) begin
                wd <= wd + 1'b1;
            end

            if (timeout) begin
                state     <= IDLE;
                FRAME_ERR <= 1'b1;
                ext       <= 1'b0;
                brk       <= 1'b0;
                skip      <= '0;
            end else if (fall) begin
                unique case (state)
                    IDLE: begin
                        if (!data_f) begin
                            state <= DATA;
                            bitn  <= '0;
                        end
                    end
                    DATA: begin
                        shreg[bitn] <= data_f;
                        if (bitn == 3'd7) begin
                            state <= PARITY;
                        end else begin
                            bitn <= bitn + 1'b1;
                        end
                    end
                    PARITY: begin
                        par   <= data_f;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!data_f || !(^{shreg, par})) begin
                            FRAME_ERR <= 1'b1;
                            ext       <= 1'b0;
                            brk       <= 1'b0;
                            skip      <= '0;
                        end else if (skip != '0) begin
                            skip <= skip - 1'b1;
                        end else if (shreg == PS2_PAUSE) begin
                            skip <= PAUSE_SKIP;
                            ext  <= 1'b0;
                            brk  <= 1'b0;
                        end else if (shreg == PS2_EXT) begin
                            ext <= 1'b1;
                        end else if (shreg == PS2_BRK) begin
                            brk <= 1'b1;
                        end else if (is_discard(shreg) ||
                                     (ext && is_fake_shift(shreg))) begin
                            ext <= 1'b0;
                            brk <= 1'b0;
                        end else begin
                            KEY_STROBE   <= 1'b1;
                            KEY_CODE     <= shreg;
                            KEY_PRESSED  <= ~brk;
                            KEY_EXTENDED <= ext;
                            ext          <= 1'b0;
                            brk          <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx.
// Expected key events are queued at send time and popped on each strobe.
module tb_ps2_keyboard_rx;

    localparam int F = 8;
    localparam int T = 1200;
    localparam int H = 30;

    logic       CLK12 = 1'b0;
    logic       RESET;
    logic       PS2_CLK;
    logic       PS2_DATA;
    logic       KEY_STROBE;
    logic       KEY_PRESSED;
    logic [7:0] KEY_CODE;
    logic       KEY_EXTENDED;
    logic       FRAME_ERR;

    typedef struct packed {
        logic [7:0] code;
        logic       pressed;
        logic       ext;
    } ev_t;

    ev_t sb[$];
    ev_t exp_ev;
    int  checks = 0;
    int  errors = 0;
    int  err_seen = 0;
    int  strobe_seen = 0;

    ps2_keyboard_rx #(.FILTER_LEN(F), .BIT_TIMEOUT(T)) dut (
        .CLK12        (CLK12),
        .RESET        (RESET),
        .PS2_CLK      (PS2_CLK),
        .PS2_DATA     (PS2_DATA),
        .KEY_STROBE   (KEY_STROBE),
        .KEY_PRESSED  (KEY_PRESSED),
        .KEY_CODE     (KEY_CODE),
        .KEY_EXTENDED (KEY_EXTENDED),
        .FRAME_ERR    (FRAME_ERR)
    );

    always #5 CLK12 = ~CLK12;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    always @(negedge CLK12) begin
        if (RESET === 1'b0 && KEY_STROBE === 1'b1) begin
            strobe_seen++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got code=%h pressed=%b ext=%b, required no strobe",
                         KEY_CODE, KEY_PRESSED, KEY_EXTENDED);
            end else begin
                exp_ev = sb.pop_front();
                if ({KEY_CODE, KEY_PRESSED, KEY_EXTENDED} !== exp_ev) begin
                    errors++;
                    $display("FAIL event: got code=%h pressed=%b ext=%b, required code=%h pressed=%b ext=%b",
                             KEY_CODE, KEY_PRESSED, KEY_EXTENDED,
                             exp_ev.code, exp_ev.pressed, exp_ev.ext);
                end
            end
        end
        if (RESET === 1'b0 && FRAME_ERR === 1'b1) err_seen++;
    end

    task automatic push(input logic [7:0] c, input logic p, input logic e);
        sb.push_back({c, p, e});
    endtask

    task automatic send_bit(input logic b);
        @(negedge CLK12);
        PS2_DATA = b;
        repeat (H) @(negedge CLK12);
        PS2_CLK = 1'b0;
        repeat (H) @(negedge CLK12);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ bad_par);
        send_bit(1'b1);
        repeat (20) @(negedge CLK12);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: got %0d pending events, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        RESET    = 1'b1;
        PS2_CLK  = 1'b1;
        PS2_DATA = 1'b1;
        repeat (5) @(negedge CLK12);
        checks++;
        if ({KEY_STROBE, KEY_PRESSED, KEY_CODE, KEY_EXTENDED, FRAME_ERR} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got strobe=%b pressed=%b code=%h ext=%b err=%b, required all 0",
                     KEY_STROBE, KEY_PRESSED, KEY_CODE, KEY_EXTENDED, FRAME_ERR);
        end
        RESET = 1'b0;
        repeat (5) @(negedge CLK12);
    endtask

    task automatic test_make;
        logic [7:0] d;
        d = 8'h1C;
        push(8'h1C, 1'b1, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(~^d);
        @(negedge CLK12);
        PS2_DATA = 1'b1;
        repeat (H) @(negedge CLK12);
        PS2_CLK = 1'b0;
        for (int k = 1; k <= H; k++) begin
            @(negedge CLK12);
            if (k == F + 2 || k == F + 4) begin
                checks++;
                if (KEY_STROBE !== 1'b0) begin
                    errors++;
                    $display("FAIL make_strobe_window: cycle %0d got %b, required 0", k, KEY_STROBE);
                end
            end
            if (k == F + 3) begin
                checks++;
                if (KEY_STROBE !== 1'b1) begin
                    errors++;
                    $display("FAIL make_strobe_latency: cycle %0d got %b, required 1", k, KEY_STROBE);
                end
            end
            if (k == H) PS2_CLK = 1'b1;
        end
        repeat (20) @(negedge CLK12);
        check_drained("make");
    endtask

    task automatic test_break;
        int s0;
        s0 = strobe_seen;
        push(8'h1C, 1'b0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        checks++;
        if (strobe_seen - s0 != 1) begin
            errors++;
            $display("FAIL break_strobes: got %0d, required 1", strobe_seen - s0);
        end
        checks++;
        if (KEY_PRESSED !== 1'b0 || KEY_CODE !== 8'h1C) begin
            errors++;
            $display("FAIL break_hold: got pressed=%b code=%h, required 0 1c", KEY_PRESSED, KEY_CODE);
        end
        check_drained("break");
    endtask

    task automatic test_extended;
        push(8'h75, 1'b1, 1'b1);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        checks++;
        if (KEY_EXTENDED !== 1'b1 || KEY_PRESSED !== 1'b1) begin
            errors++;
            $display("FAIL ext_make_hold: got ext=%b pressed=%b, required 1 1", KEY_EXTENDED, KEY_PRESSED);
        end
        push(8'h75, 1'b0, 1'b1);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        checks++;
        if (KEY_EXTENDED !== 1'b1 || KEY_PRESSED !== 1'b0) begin
            errors++;
            $display("FAIL ext_break_hold: got ext=%b pressed=%b, required 1 0", KEY_EXTENDED, KEY_PRESSED);
        end
        push(8'h16, 1'b1, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h16, 1'b0);
        check_drained("extended");
    endtask

    task automatic test_parity_err;
        int s0;
        int e0;
        s0 = strobe_seen;
        e0 = err_seen;
        send_byte(8'h1C, 1'b1);
        checks++;
        if (err_seen - e0 != 1 || strobe_seen != s0) begin
            errors++;
            $display("FAIL parity_err: got errs=%0d strobes=%0d, required 1 0",
                     err_seen - e0, strobe_seen - s0);
        end
        push(8'h16, 1'b1, 1'b0);
        send_byte(8'h16, 1'b0);
        checks++;
        if (KEY_CODE !== 8'h16 || err_seen - e0 != 1) begin
            errors++;
            $display("FAIL parity_recover: got code=%h errs=%0d, required 16 1", KEY_CODE, err_seen - e0);
        end
        check_drained("parity");
    endtask

    task automatic test_timeout;
        int e0;
        int first_k;
        int n_err;
        logic [7:0] d;
        d = 8'h5A;
        e0 = err_seen;
        send_byte(8'hE0, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        @(negedge CLK12);
        PS2_DATA = d[3];
        repeat (H) @(negedge CLK12);
        PS2_CLK = 1'b0;
        first_k = -1;
        n_err = 0;
        for (int k = 1; k <= T + F + 40; k++) begin
            @(negedge CLK12);
            if (k == H) PS2_CLK = 1'b1;
            if (FRAME_ERR === 1'b1) begin
                n_err++;
                if (first_k < 0) first_k = k;
            end
        end
        checks++;
        if (first_k != F + 2 + T || n_err != 1) begin
            errors++;
            $display("FAIL timeout_timing: got cycle %0d width %0d, required cycle %0d width 1",
                     first_k, n_err, F + 2 + T);
        end
        PS2_DATA = 1'b1;
        push(8'h1C, 1'b1, 1'b0);
        send_byte(8'h1C, 1'b0);
        checks++;
        if (KEY_EXTENDED !== 1'b0 || err_seen - e0 != 1) begin
            errors++;
            $display("FAIL timeout_clears_flags: got ext=%b errs=%0d, required 0 1",
                     KEY_EXTENDED, err_seen - e0);
        end
        check_drained("timeout");
    endtask

    task automatic test_glitch;
        int e0;
        e0 = err_seen;
        PS2_DATA = 1'b0;
        for (int g = 0; g < 5; g++) begin
            @(negedge CLK12);
            PS2_CLK = 1'b0;
            repeat (3) @(negedge CLK12);
            PS2_CLK = 1'b1;
            repeat (10) @(negedge CLK12);
        end
        repeat (T + 50) @(negedge CLK12);
        PS2_DATA = 1'b1;
        checks++;
        if (err_seen != e0) begin
            errors++;
            $display("FAIL glitch_ignored: got %0d errors, required 0", err_seen - e0);
        end
        push(8'h16, 1'b1, 1'b0);
        send_byte(8'h16, 1'b0);
        check_drained("glitch");
    endtask

    task automatic test_pause;
        logic [7:0] seq [8];
        int s0;
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        s0 = strobe_seen;
        for (int i = 0; i < 8; i++) send_byte(seq[i], 1'b0);
        checks++;
        if (strobe_seen != s0) begin
            errors++;
            $display("FAIL pause_silent: got %0d strobes, required 0", strobe_seen - s0);
        end
        push(8'h29, 1'b1, 1'b0);
        send_byte(8'h29, 1'b0);
        checks++;
        if (KEY_CODE !== 8'h29) begin
            errors++;
            $display("FAIL pause_after: got code=%h, required 29", KEY_CODE);
        end
        check_drained("pause");
    endtask

    task automatic test_reset_midframe;
        int s0;
        int e0;
        logic [7:0] d;
        d = 8'h5A;
        s0 = strobe_seen;
        e0 = err_seen;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        @(negedge CLK12);
        RESET = 1'b1;
        repeat (3) @(negedge CLK12);
        checks++;
        if ({KEY_STROBE, KEY_PRESSED, KEY_CODE, KEY_EXTENDED, FRAME_ERR} !== 12'h000) begin
            errors++;
            $display("FAIL midframe_reset_outputs: got pressed=%b code=%h ext=%b, required all 0",
                     KEY_PRESSED, KEY_CODE, KEY_EXTENDED);
        end
        PS2_CLK  = 1'b1;
        PS2_DATA = 1'b1;
        repeat (3) @(negedge CLK12);
        RESET = 1'b0;
        repeat (T + 50) @(negedge CLK12);
        checks++;
        if (strobe_seen != s0 || err_seen != e0) begin
            errors++;
            $display("FAIL midframe_abort: got strobes=%0d errs=%0d, required 0 0",
                     strobe_seen - s0, err_seen - e0);
        end
        push(8'h1C, 1'b1, 1'b0);
        send_byte(8'h1C, 1'b0);
        check_drained("midframe");
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_parity_err();
        test_timeout();
        test_glitch();
        test_pause();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
